// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor, BPC bits per clock, LSB first.
// Sum bits refill operand A from the MSB side, so A's register ends up holding the result.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BPC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_mode;
  logic             r_c;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CW-1:0]    r_cnt;

  logic [BPC:0]         w_c;
  logic [BPC-1:0]       w_s;
  logic [WIDTH+BPC-1:0] w_cat;
  logic [WIDTH-1:0]     w_res;
  logic                 w_last;
  logic                 w_ovf;

  assign w_c[0] = r_c;

  // Full add/sub slices; carry/borrow ripples through all BPC bits in one cycle.
  for (genvar i = 0; i < BPC; i++) begin : g_slice
    logic w_p;
    assign w_p      = r_x[i] ^ r_y[i];
    assign w_s[i]   = w_p ^ w_c[i];
    assign w_c[i+1] = r_mode ? ((~r_x[i] & r_y[i]) | (~w_p & w_c[i]))
                             : ((r_x[i] & r_y[i]) | (w_c[i] & w_p));
  end

  assign w_cat  = {w_s, r_x};
  assign w_res  = w_cat[WIDTH+BPC-1:BPC];
  assign w_last = (r_cnt == CW'(N - 1));
  assign w_ovf  = (r_mode ? (r_amsb != r_bmsb) : (r_amsb == r_bmsb))
                  && (w_res[WIDTH-1] != r_amsb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= 1'b0;
      r_c     <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x     <= a;
            r_y     <= b;
            r_mode  <= mode;
            r_c     <= 1'b0;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_x   <= w_res;
          r_y   <= r_y >> BPC;
          r_c   <= w_c[BPC];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            result  <= w_res;
            carry   <= w_c[BPC];
            ovf     <= w_ovf;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: eight WIDTH/BPC configurations run side by side,
// each checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_addsub;
  localparam int NCFG = 8;
  localparam int NOPS = 40;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   nfin = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_w(input int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int cfg_b(input int i);
    return 1 << (i % 4);
  endfunction

  // {carry, ovf, result} from plain integer arithmetic
  function automatic logic [65:0] model(input int w, input longint unsigned x,
                                        input longint unsigned y, input bit m);
    longint unsigned full, mask;
    longint sx, sy, sr, lim;
    bit c, v;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sx = longint'(x);
    sy = longint'(y);
    if (sx >= lim) sx = sx - 2 * lim;
    if (sy >= lim) sy = sy - 2 * lim;
    if (m) begin
      full = x - y;
      c    = (x < y);
      sr   = sx - sy;
    end else begin
      full = x + y;
      c    = (full >> w) != 0;
      sr   = sx + sy;
    end
    v = (sr >= lim) || (sr < -lim);
    return {c, v, full & mask};
  endfunction

  task automatic chk(input int w, input int bp, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL w%0d b%0d %s: got %0h want %0h", w, bp, nm, act, exp);
    end
  endtask

  task automatic mark_fin();
    nfin++;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int B = cfg_b(g);
    localparam int N = W / B;

    logic         rst_n, start, mode, busy, done, carry, ovf;
    logic [W-1:0] a, b, result, held;
    longint unsigned q_r[$];
    bit              q_c[$];
    bit              q_v[$];
    int              q_t[$];

    serial_addsub #(.WIDTH(W), .BPC(B)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .a(a), .b(b), .busy(busy), .done(done),
      .result(result), .carry(carry), .ovf(ovf)
    );

    // Monitor: pops on every done pulse, otherwise demands the held result.
    always @(negedge clk) begin
      if (!rst_n) begin
        q_r.delete();
        q_c.delete();
        q_v.delete();
        q_t.delete();
        held = '0;
      end else begin
        chk(W, B, "busy_and_done", busy & done, 0);
        if (done) begin
          chk(W, B, "done_expected", q_r.size() != 0, 1);
          if (q_r.size() != 0) begin
            chk(W, B, "result", result, q_r[0]);
            chk(W, B, "carry", carry, q_c[0]);
            chk(W, B, "ovf", ovf, q_v[0]);
            chk(W, B, "latency", cyc, q_t[0]);
            held = W'(q_r[0]);
            void'(q_r.pop_front());
            void'(q_c.pop_front());
            void'(q_v.pop_front());
            void'(q_t.pop_front());
          end
        end else begin
          chk(W, B, "hold", result, held);
        end
      end
    end

    initial begin : stim
      logic [W-1:0] ta, tbv, msb;
      logic         tm;
      logic [65:0]  e;
      int           kind, gap, s, tmo;
      msb = '0;
      msb[W-1] = 1'b1;
      s = (N - 1) / 2;
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk(W, B, "rst_busy", busy, 0);
      chk(W, B, "rst_done", done, 0);
      chk(W, B, "rst_result", result, 0);
      chk(W, B, "rst_carry", carry, 0);
      chk(W, B, "rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int j = 0; j < NOPS; j++) begin
        kind = 0;
        gap  = $urandom_range(0, 2);
        tm   = 1'($urandom);
        ta   = W'($urandom);
        tbv  = W'($urandom);
        case (j)
          0: begin tm = 1'b0; ta = '1; tbv = W'(1); end
          1: begin tm = 1'b0; ta = msb - W'(1); tbv = W'(1); end
          2: begin tm = 1'b1; ta = msb; tbv = W'(1); end
          3: begin tm = 1'b1; ta = W'(3); tbv = W'(5); end
          4: begin tm = 1'b1; ta = W'(5); tbv = W'(5); end
          5: begin tm = 1'b0; ta = W'(8'h9C); tbv = W'(8'h64); kind = 1; end
          6: kind = 2;
          8: gap = 0;
          default: begin
            if ($urandom_range(0, 9) == 0) kind = 1;
            else if ($urandom_range(0, 9) == 0) kind = 2;
          end
        endcase
        repeat (gap) @(negedge clk);
        start = 1'b1;
        mode  = tm;
        a     = ta;
        b     = tbv;
        e = model(W, 64'(ta), 64'(tbv), tm);
        q_r.push_back(e[63:0]);
        q_c.push_back(e[65]);
        q_v.push_back(e[64]);
        q_t.push_back(cyc + 1 + N);
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        chk(W, B, "busy_after_start", busy, 1);
        chk(W, B, "done_after_start", done, 0);
        repeat (s) @(negedge clk);
        if (kind == 1) begin
          start = 1'b1;
          mode  = 1'($urandom);
          a     = W'($urandom);
          b     = W'($urandom);
          @(negedge clk);
          start = 1'b0;
        end else if (kind == 2) begin
          rst_n = 1'b0;
          start = 1'b1;
          @(negedge clk);
          chk(W, B, "abort_busy", busy, 0);
          chk(W, B, "abort_done", done, 0);
          chk(W, B, "abort_result", result, 0);
          chk(W, B, "abort_carry", carry, 0);
          chk(W, B, "abort_ovf", ovf, 0);
          @(negedge clk);
          rst_n = 1'b1;
          start = 1'b0;
          @(negedge clk);
          chk(W, B, "start_in_reset_ignored", busy, 0);
        end
        if (kind != 2) begin
          tmo = 0;
          while (!done && tmo < N + 4) begin
            @(negedge clk);
            tmo++;
          end
          chk(W, B, "done_seen", done, 1);
        end
      end
      @(negedge clk);
      chk(W, B, "queue_empty", q_r.size(), 0);
      mark_fin();
    end
  end

  initial begin
    for (int t = 0; t < 20000 && nfin < NCFG; t++) @(negedge clk);
    chk(0, 0, "configs_finished", nfin, NCFG);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
